// File: rtl/coupling_gain_slewer.sv
// coupling_gain_slewer: slew-limits the PAC and harmonic coupling gains toward clamped Q-format targets,
// then dwells at target before reporting a settle and latching the coupling mode.
module coupling_gain_slewer #(
    parameter int WIDTH        = 18,
    parameter int FRAC         = 14,
    parameter int STEP         = 8,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic [1:0]              coupling_mode,
    input  logic signed [WIDTH-1:0] target_pac_gain,
    input  logic signed [WIDTH-1:0] target_harmonic_gain,
    input  logic                    freeze,
    output logic signed [WIDTH-1:0] pac_gain_out,
    output logic signed [WIDTH-1:0] harmonic_gain_out,
    output logic [1:0]              effective_mode,
    output logic                    slewing,
    output logic                    settled_pulse
);
    localparam int CW = $clog2(DWELL_CYCLES + 1);
    localparam logic signed [WIDTH-1:0] ONE      = WIDTH'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] HARM_RST = WIDTH'(1 << (FRAC - 3));
    localparam logic signed [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic signed [WIDTH:0]   STEP_S   = (WIDTH + 1)'(STEP);
    localparam logic [CW-1:0]           LAST     = CW'(DWELL_CYCLES - 1);
    typedef enum logic [1:0] {SETTLED = 2'd0, SLEWING = 2'd1, DWELL = 2'd2} state_t;
    state_t state, state_n;
    logic signed [WIDTH-1:0] pac_t, harm_t, pac_s, harm_s, pac_n, harm_n;
    logic [CW-1:0] cnt, cnt_n;
    logic tick, at_tgt, done, settle;
    function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH-1:0] t);
        return t[WIDTH-1] ? '0 : (t > ONE ? ONE : t);
    endfunction
    // difference is one bit wider than the operands so it can never wrap
    function automatic logic signed [WIDTH-1:0] slew(input logic signed [WIDTH-1:0] o, input logic signed [WIDTH-1:0] t);
        logic signed [WIDTH:0] d;
        d = $signed({t[WIDTH-1], t}) - $signed({o[WIDTH-1], o});
        return d > STEP_S ? o + STEP_W : (d < -STEP_S ? o - STEP_W : t);
    endfunction
    always_comb begin
        pac_t   = clamp(target_pac_gain);
        harm_t  = clamp(target_harmonic_gain);
        pac_s   = slew(pac_gain_out, pac_t);
        harm_s  = slew(harmonic_gain_out, harm_t);
        at_tgt  = pac_gain_out == pac_t && harmonic_gain_out == harm_t;
        done    = pac_s == pac_t && harm_s == harm_t;
        tick    = clk_en && !freeze;
        state_n = state;
        pac_n   = pac_gain_out;
        harm_n  = harmonic_gain_out;
        cnt_n   = cnt;
        settle  = 1'b0;
        if (tick) begin
            case (state)
                SLEWING: begin
                    pac_n   = pac_s;
                    harm_n  = harm_s;
                    state_n = done ? DWELL : SLEWING;
                    cnt_n   = done ? '0 : cnt;
                end
                DWELL: begin
                    state_n = !at_tgt ? SLEWING : (cnt == LAST ? SETTLED : DWELL);
                    settle  = at_tgt && cnt == LAST;
                    cnt_n   = at_tgt && cnt != LAST ? cnt + 1'b1 : cnt;
                    pac_n   = at_tgt ? pac_gain_out : pac_s;
                    harm_n  = at_tgt ? harmonic_gain_out : harm_s;
                end
                default: begin
                    state_n = at_tgt ? SETTLED : SLEWING;
                    pac_n   = pac_s;
                    harm_n  = harm_s;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= SETTLED;
            pac_gain_out      <= ONE;
            harmonic_gain_out <= HARM_RST;
            effective_mode    <= 2'b00;
            cnt               <= '0;
            settled_pulse     <= 1'b0;
        end else begin
            state             <= state_n;
            pac_gain_out      <= pac_n;
            harmonic_gain_out <= harm_n;
            cnt               <= cnt_n;
            settled_pulse     <= settle;
            if (settle) effective_mode <= coupling_mode;
        end
    end
    assign slewing = state == SLEWING;
endmodule

// File: tb/tb_coupling_gain_slewer.sv
// tb_coupling_gain_slewer: directed scenarios plus randomized traffic, all checked cycle by cycle
// against an integer reference model of the slewer.
module tb_coupling_gain_slewer;
    localparam int STEP = 8;
    localparam int DW   = 4;
    localparam int ONE  = 16384;

    logic clk = 1'b0;
    logic rst, clk_en, freeze;
    logic [1:0] coupling_mode;
    logic signed [17:0] target_pac_gain, target_harmonic_gain;
    logic signed [17:0] pac_gain_out, harmonic_gain_out;
    logic [1:0] effective_mode;
    logic slewing, settled_pulse;

    always #5 clk = ~clk;

    coupling_gain_slewer #(.WIDTH(18), .FRAC(14), .STEP(STEP), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .coupling_mode(coupling_mode),
        .target_pac_gain(target_pac_gain), .target_harmonic_gain(target_harmonic_gain),
        .freeze(freeze), .pac_gain_out(pac_gain_out), .harmonic_gain_out(harmonic_gain_out),
        .effective_mode(effective_mode), .slewing(slewing), .settled_pulse(settled_pulse)
    );

    int checks = 0;
    int failures = 0;

    typedef enum {M_SETTLED, M_SLEWING, M_DWELL} phase_t;
    phase_t m_ph;
    int m_pac, m_harm, m_mode, m_cnt;
    bit m_pulse;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int t);
        return t < 0 ? 0 : (t > ONE ? ONE : t);
    endfunction

    function automatic int approach(input int o, input int t);
        int d = t - o;
        if (d > STEP) return o + STEP;
        if (d < -STEP) return o - STEP;
        return t;
    endfunction

    task automatic model();
        int tp, th;
        m_pulse = 0;
        if (rst) begin
            m_ph = M_SETTLED; m_pac = ONE; m_harm = 2048; m_mode = 0; m_cnt = 0;
            return;
        end
        if (!clk_en || freeze) return;
        tp = clampi(int'(target_pac_gain));
        th = clampi(int'(target_harmonic_gain));
        if (m_ph == M_DWELL && tp == m_pac && th == m_harm) begin
            if (m_cnt == DW - 1) begin
                m_ph = M_SETTLED; m_pulse = 1; m_mode = int'(coupling_mode);
            end else m_cnt++;
        end else if (m_ph == M_SLEWING) begin
            m_pac = approach(m_pac, tp);
            m_harm = approach(m_harm, th);
            if (m_pac == tp && m_harm == th) begin
                m_ph = M_DWELL; m_cnt = 0;
            end
        end else if (tp != m_pac || th != m_harm) begin
            m_ph = M_SLEWING;
            m_pac = approach(m_pac, tp);
            m_harm = approach(m_harm, th);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        check("pac", int'(pac_gain_out), m_pac);
        check("harm", int'(harmonic_gain_out), m_harm);
        check("mode", int'(effective_mode), m_mode);
        check("slewing", int'(slewing), int'(m_ph == M_SLEWING));
        check("pulse", int'(settled_pulse), int'(m_pulse));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_tgt(input int p, input int h);
        target_pac_gain = 18'(p);
        target_harmonic_gain = 18'(h);
    endtask

    initial begin
        rst = 1; clk_en = 0; freeze = 0; coupling_mode = 2'b00;
        set_tgt(ONE, 2048);
        step();
        rst = 0;
        check("rst_pac", int'(pac_gain_out), 16384);
        check("rst_harm", int'(harmonic_gain_out), 2048);
        check("rst_mode", int'(effective_mode), 0);
        check("rst_slewing", int'(slewing), 0);

        set_tgt(8192, 8192); coupling_mode = 2'b01; clk_en = 1;
        for (int t = 1; t <= 1028; t++) begin
            step();
            if (t == 1) begin
                check("xf_t1_slewing", int'(slewing), 1);
                check("xf_t1_pac", int'(pac_gain_out), 16376);
                check("xf_t1_harm", int'(harmonic_gain_out), 2056);
            end
            if (t == 767) check("xf_harm767", int'(harmonic_gain_out), 8184);
            if (t == 768) check("xf_harm768", int'(harmonic_gain_out), 8192);
            if (t == 1023) check("xf_slew1023", int'(slewing), 1);
            if (t == 1023) check("xf_pac1023", int'(pac_gain_out), 8200);
            if (t == 1024) check("xf_pac1024", int'(pac_gain_out), 8192);
            if (t == 1024) check("xf_slew1024", int'(slewing), 0);
            if (t == 1027) check("xf_pulse1027", int'(settled_pulse), 0);
            if (t == 1028) check("xf_pulse1028", int'(settled_pulse), 1);
            if (t == 1028) check("xf_mode", int'(effective_mode), 1);
        end
        clk_en = 0;
        step();
        check("xf_pulse_clear", int'(settled_pulse), 0);

        clk_en = 1; set_tgt(8195, -100);
        for (int t = 1; t <= 1024; t++) begin
            step();
            if (t == 1) check("rem_pac1", int'(pac_gain_out), 8195);
            if (t == 1023) check("clamp_harm1023", int'(harmonic_gain_out), 8);
            if (t == 1024) check("clamp_harm1024", int'(harmonic_gain_out), 0);
        end
        check("rem_pac_hold", int'(pac_gain_out), 8195);
        run(4);
        check("rem_settle", int'(settled_pulse), 1);
        set_tgt(20000, -100);
        for (int t = 1; t <= 1024; t++) begin
            step();
            if (t == 1023) check("clamp_pac1023", int'(pac_gain_out), 16379);
            if (t == 1024) check("clamp_pac1024", int'(pac_gain_out), 16384);
        end
        run(4);
        check("clamp_settle", int'(settled_pulse), 1);

        set_tgt(8192, -100);
        run(548);
        check("hold_start", int'(pac_gain_out), 12000);
        freeze = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("freeze_pac", int'(pac_gain_out), 12000);
        end
        freeze = 0;
        step();
        check("freeze_resume", int'(pac_gain_out), 11992);
        clk_en = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("clken_pac", int'(pac_gain_out), 11992);
        end
        clk_en = 1;
        step();
        check("clken_resume", int'(pac_gain_out), 11984);

        run(474);
        check("dw_reach", int'(pac_gain_out), 8192);
        run(2);
        set_tgt(8000, -100);
        step();
        check("dw_retarget_slew", int'(slewing), 1);
        check("dw_retarget_pac", int'(pac_gain_out), 8184);
        check("dw_retarget_pulse", int'(settled_pulse), 0);
        run(27);
        check("dw_resettle", int'(settled_pulse), 1);

        set_tgt(ONE, -100);
        run(250);
        check("mid_pac", int'(pac_gain_out), 10000);
        rst = 1;
        step();
        rst = 0;
        check("mid_rst_pac", int'(pac_gain_out), 16384);
        check("mid_rst_harm", int'(harmonic_gain_out), 2048);
        check("mid_rst_slew", int'(slewing), 0);
        check("mid_rst_pulse", int'(settled_pulse), 0);
        step();
        check("mid_rst_pulse2", int'(settled_pulse), 0);

        for (int i = 0; i < 6000; i++) begin
            rst = $urandom_range(0, 799) == 0;
            clk_en = $urandom_range(0, 7) != 0;
            freeze = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 49) == 0) coupling_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    set_tgt(int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 40000)) - 20000);
                else
                    set_tgt(m_pac + int'($urandom_range(0, 200)) - 100, m_harm + int'($urandom_range(0, 200)) - 100);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coupling_gain_slewer.md
COUPLING_GAIN_SLEWER -- requirements
Module: coupling_gain_slewer

Interface
REQ-001 SHALL have parameter WIDTH, default 18, signed gain word width.
REQ-002 SHALL have parameter FRAC, default 14, fractional bits (Q14, 1.0 = 16384).
REQ-003 SHALL have parameter STEP, default 8, maximum gain change per clk_en tick, range 1..16384.
REQ-004 SHALL have parameter DWELL_CYCLES, default 4, ticks held at target before settling, range >=1.
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port clk_en, input, 1, tick enable; state advances only when high.
REQ-008 SHALL have port coupling_mode, input, 2, mode from the coupling mode controller (00 modulatory, 01 transition, 10 harmonic).
REQ-009 SHALL have port target_pac_gain, input, WIDTH signed, requested PAC gain.
REQ-010 SHALL have port target_harmonic_gain, input, WIDTH signed, requested harmonic gain.
REQ-011 SHALL have port freeze, input, 1, holds all state and outputs while high.
REQ-012 SHALL have port pac_gain_out, output, WIDTH signed, slew-limited PAC gain.
REQ-013 SHALL have port harmonic_gain_out, output, WIDTH signed, slew-limited harmonic gain.
REQ-014 SHALL have port effective_mode, output, 2, coupling_mode as captured at the last settle.
REQ-015 SHALL have port slewing, output, 1, high while state is SLEWING.
REQ-016 SHALL have port settled_pulse, output, 1, one-clk pulse on entry to SETTLED.

Function
REQ-017 SHALL clamp each target to [0, 16384] before use: negative -> 0, above 16384 -> 16384.
REQ-018 SHALL sample targets and coupling_mode on every clk_en tick where freeze is low; no input registering stage.
REQ-019 SHALL, per tick, move each output toward its clamped target by min(STEP, |target - output|), never overshooting.
REQ-020 SHALL compute differences in WIDTH+1 bits so no intermediate overflows.
REQ-021 SHALL slew the two gains independently with the same STEP, so they may arrive on different ticks.
REQ-022 SHALL implement states SETTLED, SLEWING, DWELL.
REQ-023 SHALL go SETTLED -> SLEWING on a tick where either clamped target differs from its output; the first step is applied on that same edge.
REQ-024 SHALL go SLEWING -> DWELL and clear the dwell counter on the tick where both outputs reach their targets after stepping.
REQ-025 SHALL in DWELL increment the dwell counter each tick with both targets equal to outputs, and go DWELL -> SETTLED on the tick the counter equals DWELL_CYCLES-1.
REQ-026 SHALL return DWELL -> SLEWING, stepping on that edge, if either target changes during DWELL.
REQ-027 SHALL on entering SETTLED assert settled_pulse for exactly one clk cycle, cleared on the next clk edge regardless of clk_en.
REQ-028 SHALL on entering SETTLED load effective_mode from coupling_mode sampled on that edge.
REQ-029 SHALL treat a target change during SLEWING as a new destination, with no state change.
REQ-030 SHALL, with clk_en low or freeze high, hold outputs, state and dwell counter; settled_pulse still self-clears.
REQ-031 SHALL decode any illegal state as SETTLED on the next tick.

Reset
REQ-032 SHALL on rst set pac_gain_out=16384, harmonic_gain_out=2048, effective_mode=00, state SETTLED, slewing=0, settled_pulse=0, dwell counter=0.
REQ-033 SHALL let rst override clk_en and freeze, and abort any slew or dwell in progress.

Verification (STEP=8, DWELL_CYCLES=4)
REQ-034 SHALL cover reset: assert rst one cycle -> outputs 16384/2048, mode 00, slewing 0.
REQ-035 SHALL cover crossfade: targets 8192/8192, mode 01, clk_en every cycle -> pac -8/tick and reaches 8192 at tick 1024; harmonic +8/tick and reaches 8192 at tick 768; slewing high for ticks 1..1024; settled_pulse at tick 1028; effective_mode 01.
REQ-036 SHALL cover remainder and clamp: targets 8195 and -100 from 8192/8192 -> pac reaches 8195 in one tick without overshoot; harmonic reaches 0 in 1024 ticks; target 20000 -> 16384.
REQ-037 SHALL cover hold: freeze high for 10 cycles mid-slew at pac=12000 -> pac stays 12000, then resumes at -8/tick; the same holds with clk_en low.
REQ-038 SHALL cover retarget in DWELL: target changes at dwell count 2 -> SLEWING, step applied, no settled_pulse.
REQ-039 SHALL cover reset mid-slew: rst at pac=10000 -> next cycle 16384/2048, SETTLED, no settled_pulse.
